ysyx_23060221_xbar: RTL

- 1-to-2 AXI4 address router directly downstream of the core's IFU/EXU arbiter.
- Accepts the arbiter's single merged AXI4 master stream on the s_ side.
- Routes each transaction by address to one of two slaves:
  - m0: external memory / io_master (read+write);
  - m1: CLINT (read-only).
- Requests to unmapped addresses, and writes to the CLINT, are terminated locally with error responses. Independent read and write state machines; one outstanding transaction per direction.

---
 rtl/ysyx_23060221_xbar.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060221_xbar.sv
// 1-to-2 AXI4 address router: memory on m0, read-only CLINT on m1.
// Unmapped accesses and CLINT writes are answered locally with error responses.
module ysyx_23060221_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_SIZE = 32'h0001_0000,
  parameter logic [31:0] NULL_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic [3:0]  s_awid,
  input  logic [7:0]  s_awlen,
  input  logic [2:0]  s_awsize,
  input  logic [1:0]  s_awburst,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wlast,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  output logic [3:0]  s_bid,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [1:0]  s_rresp,
  output logic [31:0] s_rdata,
  output logic        s_rlast,
  output logic [3:0]  s_rid,
  output logic        m0_awvalid,
  input  logic        m0_awready,
  output logic [31:0] m0_awaddr,
  output logic [3:0]  m0_awid,
  output logic [7:0]  m0_awlen,
  output logic [2:0]  m0_awsize,
  output logic [1:0]  m0_awburst,
  output logic        m0_wvalid,
  input  logic        m0_wready,
  output logic [31:0] m0_wdata,
  output logic [3:0]  m0_wstrb,
  output logic        m0_wlast,
  input  logic        m0_bvalid,
  output logic        m0_bready,
  input  logic [1:0]  m0_bresp,
  input  logic [3:0]  m0_bid,
  output logic        m0_arvalid,
  input  logic        m0_arready,
  output logic [31:0] m0_araddr,
  output logic [3:0]  m0_arid,
  output logic [7:0]  m0_arlen,
  output logic [2:0]  m0_arsize,
  output logic [1:0]  m0_arburst,
  input  logic        m0_rvalid,
  output logic        m0_rready,
  input  logic [1:0]  m0_rresp,
  input  logic [31:0] m0_rdata,
  input  logic        m0_rlast,
  input  logic [3:0]  m0_rid,
  output logic        m1_arvalid,
  input  logic        m1_arready,
  output logic [31:0] m1_araddr,
  output logic [3:0]  m1_arid,
  output logic [7:0]  m1_arlen,
  output logic [2:0]  m1_arsize,
  output logic [1:0]  m1_arburst,
  input  logic        m1_rvalid,
  output logic        m1_rready,
  input  logic [1:0]  m1_rresp,
  input  logic [31:0] m1_rdata,
  input  logic        m1_rlast,
  input  logic [3:0]  m1_rid
);

  typedef enum logic [1:0] {T_MEM, T_CLINT, T_ERR} tgt_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rstate_t;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_SINK, W_ERRB} wstate_t;

  function automatic tgt_t decode(input logic [31:0] a);
    if ((a & ~(CLINT_SIZE - 32'd1)) == CLINT_BASE) return T_CLINT;
    else if (a < NULL_LIMIT) return T_ERR;
    else return T_MEM;
  endfunction

  rstate_t     rstate, rnext;
  wstate_t     wstate, wnext;
  tgt_t        r_tgt, w_tgt;
  logic [31:0] ar_addr, aw_addr;
  logic [3:0]  ar_id, aw_id;
  logic [7:0]  ar_len, aw_len, r_cnt;
  logic [2:0]  ar_size, aw_size;
  logic [1:0]  ar_burst, aw_burst;

  // ---------------- read path ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rstate <= R_IDLE;
    else       rstate <= rnext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_addr <= '0; ar_id <= '0; ar_len <= '0; ar_size <= '0; ar_burst <= '0;
      r_tgt <= T_MEM; r_cnt <= '0;
    end else if (rstate == R_IDLE && s_arvalid) begin
      ar_addr <= s_araddr; ar_id <= s_arid; ar_len <= s_arlen;
      ar_size <= s_arsize; ar_burst <= s_arburst;
      r_tgt <= decode(s_araddr); r_cnt <= s_arlen;
    end else if (rstate == R_ERR && s_rready && r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  always_comb begin
    rnext = rstate;
    case (rstate)
      R_IDLE: if (s_arvalid) rnext = (decode(s_araddr) == T_ERR) ? R_ERR : R_ADDR;
      R_ADDR: if ((r_tgt == T_CLINT) ? m1_arready : m0_arready) rnext = R_DATA;
      R_DATA: if (s_rvalid && s_rready && s_rlast) rnext = R_IDLE;
      R_ERR:  if (s_rready && r_cnt == 8'd0) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m0_rready = 1'b0; m1_rready = 1'b0;
    s_rvalid = 1'b0; s_rresp = 2'b00; s_rdata = '0; s_rlast = 1'b0; s_rid = '0;
    case (rstate)
      R_IDLE: s_arready = ~reset;
      R_ADDR: begin
        m0_arvalid = (r_tgt == T_MEM);
        m1_arvalid = (r_tgt == T_CLINT);
      end
      R_DATA: begin
        if (r_tgt == T_CLINT) begin
          s_rvalid = m1_rvalid; s_rresp = m1_rresp; s_rdata = m1_rdata;
          s_rlast = m1_rlast; s_rid = m1_rid; m1_rready = s_rready;
        end else begin
          s_rvalid = m0_rvalid; s_rresp = m0_rresp; s_rdata = m0_rdata;
          s_rlast = m0_rlast; s_rid = m0_rid; m0_rready = s_rready;
        end
      end
      R_ERR: begin
        s_rvalid = 1'b1; s_rresp = 2'b11; s_rid = ar_id;
        s_rlast = (r_cnt == 8'd0);
      end
      default: ;
    endcase
  end

  assign m0_araddr = ar_addr; assign m0_arid = ar_id; assign m0_arlen = ar_len;
  assign m0_arsize = ar_size; assign m0_arburst = ar_burst;
  assign m1_araddr = ar_addr; assign m1_arid = ar_id; assign m1_arlen = ar_len;
  assign m1_arsize = ar_size; assign m1_arburst = ar_burst;

  // ---------------- write path ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wstate <= W_IDLE;
    else       wstate <= wnext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_addr <= '0; aw_id <= '0; aw_len <= '0; aw_size <= '0; aw_burst <= '0;
      w_tgt <= T_MEM;
    end else if (wstate == W_IDLE && s_awvalid) begin
      aw_addr <= s_awaddr; aw_id <= s_awid; aw_len <= s_awlen;
      aw_size <= s_awsize; aw_burst <= s_awburst;
      w_tgt <= decode(s_awaddr);
    end
  end

  always_comb begin
    wnext = wstate;
    case (wstate)
      W_IDLE: if (s_awvalid) wnext = (decode(s_awaddr) == T_MEM) ? W_ADDR : W_SINK;
      W_ADDR: if (m0_awready) wnext = W_DATA;
      W_DATA: if (s_wvalid && m0_wready && s_wlast) wnext = W_RESP;
      W_RESP: if (m0_bvalid && s_bready) wnext = W_IDLE;
      W_SINK: if (s_wvalid && s_wlast) wnext = W_ERRB;
      W_ERRB: if (s_bready) wnext = W_IDLE;
      default: wnext = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready = 1'b0; m0_awvalid = 1'b0; m0_wvalid = 1'b0; s_wready = 1'b0;
    m0_bready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00; s_bid = '0;
    case (wstate)
      W_IDLE: s_awready = ~reset;
      W_ADDR: m0_awvalid = 1'b1;
      W_DATA: begin
        m0_wvalid = s_wvalid; s_wready = m0_wready;
      end
      W_RESP: begin
        s_bvalid = m0_bvalid; s_bresp = m0_bresp; s_bid = m0_bid;
        m0_bready = s_bready;
      end
      W_SINK: s_wready = 1'b1;
      W_ERRB: begin
        s_bvalid = 1'b1; s_bid = aw_id;
        s_bresp = (w_tgt == T_ERR) ? 2'b11 : 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_awaddr = aw_addr; assign m0_awid = aw_id; assign m0_awlen = aw_len;
  assign m0_awsize = aw_size; assign m0_awburst = aw_burst;
  assign m0_wdata = s_wdata; assign m0_wstrb = s_wstrb; assign m0_wlast = s_wlast;

endmodule
